time_set_controller: RTL and testbench

//   Sequences the clock time register from two front-panel buttons (MIN, HR).

---
 rtl/time_set_controller_if.sv | 27 ++
 rtl/time_set_controller.sv | 144 ++++++++++++++
 tb/tb_time_set_controller.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/time_set_controller_if.sv
// rtl/time_set_controller_if.sv - button/strobe inputs and mode/tick outputs of the time-set controller
interface time_set_controller_if;
    logic       one_hz_stb;
    logic       fast_stb;
    logic       btn_min;
    logic       btn_hr;
    logic [1:0] mode;
    logic       en;

    modport master (
        output one_hz_stb,
        output fast_stb,
        output btn_min,
        output btn_hr,
        input  mode,
        input  en
    );

    modport slave (
        input  one_hz_stb,
        input  fast_stb,
        input  btn_min,
        input  btn_hr,
        output mode,
        output en
    );
endinterface

// File: rtl/time_set_controller.sv
// rtl/time_set_controller.sv - debounces MIN/HR buttons and sequences time-register mode and enable tick
module time_set_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_TICKS      = 8,
    parameter int REPEAT_DIV      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    time_set_controller_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1) > 0 ? $clog2(HOLD_TICKS + 1) : 1;
    localparam int RW = $clog2(REPEAT_DIV + 1) > 0 ? $clog2(REPEAT_DIV + 1) : 1;

    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_DIV - 1);

    localparam logic [1:0] MODE_RUN = 2'd0;
    localparam logic [1:0] MODE_MIN = 2'd1;
    localparam logic [1:0] MODE_HR  = 2'd2;
    localparam logic [1:0] MODE_CLR = 2'd3;

    typedef enum logic [2:0] {RUN, SMIN, SHR, CLR1, CLR2, WREL} state_t;

    // Index 0 is MIN, index 1 is HR throughout the conditioning path.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [DW-1:0] deb_cnt [2];

    assign raw = {bus.btn_hr, bus.btn_min};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    logic dm;
    logic dh;
    assign dm = deb[0];
    assign dh = deb[1];

    state_t        state;
    logic [1:0]    mode_q;
    logic          en_q;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;
    logic          own_btn;
    logic          other_btn;

    assign own_btn   = (state == SMIN) ? dm : dh;
    assign other_btn = (state == SMIN) ? dh : dm;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            mode_q   <= MODE_RUN;
            en_q     <= 1'b0;
            hold_cnt <= '0;
            rep_cnt  <= '0;
        end else begin
            en_q <= 1'b0;
            case (state)
                RUN: begin
                    // A button transition takes priority; a coincident 1 Hz tick is dropped.
                    if (dm && dh) begin
                        state  <= CLR1;
                        mode_q <= MODE_CLR;
                    end else if (dm || dh) begin
                        state    <= dm ? SMIN : SHR;
                        mode_q   <= dm ? MODE_MIN : MODE_HR;
                        en_q     <= 1'b1;
                        hold_cnt <= (bus.fast_stb && HOLD_TICKS > 0) ? HW'(1) : '0;
                        rep_cnt  <= '0;
                    end else begin
                        en_q <= bus.one_hz_stb;
                    end
                end
                SMIN, SHR: begin
                    if (other_btn) begin
                        state    <= CLR1;
                        mode_q   <= MODE_CLR;
                        hold_cnt <= '0;
                        rep_cnt  <= '0;
                    end else if (!own_btn) begin
                        state    <= RUN;
                        mode_q   <= MODE_RUN;
                        hold_cnt <= '0;
                        rep_cnt  <= '0;
                    end else if (bus.fast_stb) begin
                        if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end else if (rep_cnt == REP_LAST) begin
                            rep_cnt <= '0;
                            en_q    <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + RW'(1);
                        end
                    end
                end
                // Mode 3 is presented one cycle ahead of the clearing tick.
                CLR1: begin
                    state <= CLR2;
                    en_q  <= 1'b1;
                end
                CLR2: begin
                    state <= WREL;
                end
                WREL: begin
                    if (!dm && !dh) begin
                        state  <= RUN;
                        mode_q <= MODE_RUN;
                    end
                end
                default: begin
                    state  <= RUN;
                    mode_q <= MODE_RUN;
                end
            endcase
        end
    end

    assign bus.mode = mode_q;
    assign bus.en   = en_q;
endmodule

// File: tb/tb_time_set_controller.sv
// tb/tb_time_set_controller.sv - directed and random checks of time_set_controller against a reference model
module tb_time_set_controller;
    localparam int D = 16;
    localparam int H = 8;
    localparam int R = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    time_set_controller_if bus ();

    time_set_controller #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_TICKS     (H),
        .REPEAT_DIV     (R)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int en_count = 0;

    // Reference model: button history, accepted levels, and a mode/age view of the sequencer.
    int         hist_min [2];
    int         hist_hr  [2];
    int         acc_min, acc_hr;
    int         run_min, run_hr;
    logic [1:0] exp_mode;
    logic       exp_en;
    int         fast_seen;
    int         clr_age;

    function automatic void model_reset();
        hist_min = '{0, 0};
        hist_hr  = '{0, 0};
        acc_min = 0; acc_hr = 0; run_min = 0; run_hr = 0;
        exp_mode = 2'd0; exp_en = 1'b0; fast_seen = 0; clr_age = 0;
    endfunction

    function automatic void accept(input int synced, inout int acc, inout int run);
        if (synced == acc) run = 0;
        else if (run + 1 == D) begin acc = synced; run = 0; end
        else run = run + 1;
    endfunction

    function automatic void model_edge();
        int pm, ph, own, other;
        pm = acc_min; ph = acc_hr;
        exp_en = 1'b0;
        if (exp_mode == 2'd0) begin
            if (pm != 0 && ph != 0) begin exp_mode = 2'd3; clr_age = 0; end
            else if (pm != 0 || ph != 0) begin
                exp_mode = (pm != 0) ? 2'd1 : 2'd2;
                exp_en = 1'b1;
                fast_seen = bus.fast_stb ? 1 : 0;
            end else exp_en = bus.one_hz_stb;
        end else if (exp_mode == 2'd3) begin
            if (clr_age >= 2) begin
                if (pm == 0 && ph == 0) exp_mode = 2'd0;
            end else begin
                clr_age = clr_age + 1;
                exp_en = (clr_age == 1);
            end
        end else begin
            own   = (exp_mode == 2'd1) ? pm : ph;
            other = (exp_mode == 2'd1) ? ph : pm;
            if (other != 0) begin exp_mode = 2'd3; clr_age = 0; end
            else if (own == 0) exp_mode = 2'd0;
            else if (bus.fast_stb) begin
                fast_seen = fast_seen + 1;
                if (fast_seen > H && (fast_seen - H) % R == 0) exp_en = 1'b1;
            end
        end
        accept(hist_min[1], acc_min, run_min);
        accept(hist_hr[1], acc_hr, run_hr);
        hist_min[1] = hist_min[0]; hist_min[0] = int'(bus.btn_min);
        hist_hr[1]  = hist_hr[0];  hist_hr[0]  = int'(bus.btn_hr);
    endfunction

    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        cyc++;
        n_checks++;
        assert (bus.mode === exp_mode) else begin
            n_fail++;
            $error("FAIL mode cycle %0d: got %0d expected %0d", cyc, bus.mode, exp_mode);
        end
        n_checks++;
        assert (bus.en === exp_en) else begin
            n_fail++;
            $error("FAIL en cycle %0d: got %0b expected %0b", cyc, bus.en, exp_en);
        end
        if (bus.en === 1'b1) en_count++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic strobe_1hz();
        bus.one_hz_stb = 1'b1; step();
        bus.one_hz_stb = 1'b0; cycles(3);
    endtask

    task automatic strobe_fast();
        bus.fast_stb = 1'b1; step();
        bus.fast_stb = 1'b0; cycles(2);
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        bus.one_hz_stb = 1'b0; bus.fast_stb = 1'b0;
        bus.btn_min = 1'b0; bus.btn_hr = 1'b0;
        cycles(3);
        reset = 1'b0;
        check_int("reset_mode", int'(bus.mode), 0);

        // 1 Hz forwarding in RUN
        en_count = 0;
        for (int i = 0; i < 3; i++) strobe_1hz();
        check_int("run_1hz_ticks", en_count, 3);

        // Bouncing MIN shorter than the debounce window is ignored
        en_count = 0;
        for (int i = 0; i < 4; i++) begin
            bus.btn_min = 1'b1; cycles(5);
            bus.btn_min = 1'b0; cycles(5);
        end
        check_int("bounce_mode", int'(bus.mode), 0);
        bus.btn_min = 1'b1; cycles(D + 5);
        check_int("smin_mode", int'(bus.mode), 1);
        check_int("smin_entry_ticks", en_count, 1);
        // 1 Hz frozen while setting
        en_count = 0;
        for (int i = 0; i < 3; i++) strobe_1hz();
        check_int("smin_1hz_ignored", en_count, 0);
        bus.btn_min = 1'b0; cycles(D + 4);
        check_int("smin_release", int'(bus.mode), 0);

        // HR hold with auto-repeat
        en_count = 0;
        bus.btn_hr = 1'b1; cycles(D + 4);
        for (int i = 0; i < 20; i++) strobe_fast();
        check_int("shr_mode", int'(bus.mode), 2);
        check_int("shr_ticks", en_count, 7);
        bus.btn_hr = 1'b0; cycles(D + 4);
        check_int("shr_release", int'(bus.mode), 0);

        // MIN then HR clears seconds and waits for full release
        bus.btn_min = 1'b1; cycles(D + 4);
        en_count = 0;
        bus.btn_hr = 1'b1; cycles(D + 6);
        check_int("clr_mode", int'(bus.mode), 3);
        check_int("clr_ticks", en_count, 1);
        for (int i = 0; i < 2; i++) strobe_1hz();
        check_int("wrel_1hz_ignored", en_count, 1);
        bus.btn_min = 1'b0; cycles(D + 4);
        check_int("wrel_one_released", int'(bus.mode), 3);
        bus.btn_hr = 1'b0; cycles(D + 4);
        check_int("wrel_exit", int'(bus.mode), 0);

        // Reset during HR auto-repeat; held button re-accepted after debounce
        bus.btn_hr = 1'b1; cycles(D + 4);
        for (int i = 0; i < 12; i++) strobe_fast();
        reset = 1'b1; bus.fast_stb = 1'b1; step();
        check_int("reset_mid_mode", int'(bus.mode), 0);
        check_int("reset_mid_en", int'(bus.en), 0);
        reset = 1'b0; bus.fast_stb = 1'b0;
        cycles(D + 4);
        check_int("rehold_mode", int'(bus.mode), 2);
        bus.btn_hr = 1'b0; cycles(D + 4);

        // Random segments of button levels with random strobes and occasional reset
        for (int s = 0; s < 250; s++) begin
            int len;
            bus.btn_min = 1'($urandom_range(0, 1));
            bus.btn_hr  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 40);
            for (int c = 0; c < len; c++) begin
                bus.fast_stb   = ($urandom_range(0, 3) == 0);
                bus.one_hz_stb = ($urandom_range(0, 5) == 0);
                reset          = ($urandom_range(0, 299) == 0);
                step();
            end
        end
        reset = 1'b0; bus.fast_stb = 1'b0; bus.one_hz_stb = 1'b0;
        bus.btn_min = 1'b0; bus.btn_hr = 1'b0;
        cycles(2 * D + 8);
        check_int("final_idle", int'(bus.mode), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
